// File: rtl/sha256_pkg.sv
// Shared constants, FSM encoding and helpers for the SHA-256 nonce feeder.
// Core ordering keeps h0 in the low word of every 256-bit chaining value.
package sha256_pkg;

  localparam logic [255:0] ShaIv = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [31:0]  PadWord   = 32'h80000000;
  localparam logic [31:0]  LenHeader = 32'h00000280;
  localparam logic [31:0]  LenDigest = 32'h00000100;

  typedef enum logic [3:0] {
    StIdle,
    StB1Req,
    StB1Wait,
    StB2Req,
    StB2Wait,
    StB3Req,
    StB3Wait,
    StEmit,
    StFinish
  } state_e;

  function automatic logic [255:0] word_reverse(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = x[32*(7-i) +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_nonce_feeder_if.sv
// Start/done handshake and data bus between the nonce feeder and the SHA-256 compression core.
interface sha256_nonce_feeder_if;
  logic         core_start;
  logic [255:0] core_h_block;
  logic [511:0] core_message;
  logic         core_done;
  logic [255:0] core_h_out;

  modport master (
    output core_start,
    output core_h_block,
    output core_message,
    input  core_done,
    input  core_h_out
  );

  modport slave (
    input  core_start,
    input  core_h_block,
    input  core_message,
    output core_done,
    output core_h_out
  );
endinterface

// File: rtl/sha256_nonce_feeder.sv
// Double-SHA-256 nonce sweep controller: the first header block is compressed once per sweep,
// then each nonce costs two more core calls and produces one digest.
module sha256_nonce_feeder
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [639:0]          header,
  input  logic [31:0]           nonce_base,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [31:0]           result_nonce,
  output logic [255:0]          digest,
  sha256_nonce_feeder_if.master core
);

  localparam logic [31:0] LastN = 32'(NUM_NONCES - 1);

  state_e       state_q;
  logic [607:0] hdr_q;  // W0..W18; W19 is always replaced by the nonce
  logic [31:0]  base_q;
  logic [31:0]  n_q;
  logic [255:0] midstate_q;
  logic [31:0]  cur_nonce;
  logic [31:0]  next_nonce;
  logic         unused_header_nonce;

  assign cur_nonce           = base_q + n_q;
  assign next_nonce          = cur_nonce + 32'd1;
  assign unused_header_nonce = ^header[31:0];

  function automatic logic [511:0] b2_message(input logic [95:0]  tail,
                                              input logic [31:0]  nonce);
    return {tail, nonce, PadWord, 320'h0, LenHeader};
  endfunction

  function automatic logic [511:0] b3_message(input logic [255:0] h_core);
    return {word_reverse(h_core), PadWord, 192'h0, LenDigest};
  endfunction

  // Core inputs are loaded on entry to each REQ state and left untouched until the next entry,
  // so they stay stable for the whole core call.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      hdr_q             <= '0;
      base_q            <= '0;
      n_q               <= '0;
      midstate_q        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      result_valid      <= 1'b0;
      result_nonce      <= '0;
      digest            <= '0;
      core.core_start   <= 1'b0;
      core.core_h_block <= '0;
      core.core_message <= '0;
    end else begin
      core.core_start <= 1'b0;
      result_valid    <= 1'b0;
      done            <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            hdr_q             <= header[639:32];
            base_q            <= nonce_base;
            n_q               <= '0;
            busy              <= 1'b1;
            core.core_start   <= 1'b1;
            core.core_h_block <= ShaIv;
            core.core_message <= header[639:128];
            state_q           <= StB1Req;
          end
        end
        StB1Req: state_q <= StB1Wait;
        StB1Wait: begin
          if (core.core_done) begin
            midstate_q        <= core.core_h_out;
            core.core_start   <= 1'b1;
            core.core_h_block <= core.core_h_out;
            core.core_message <= b2_message(hdr_q[95:0], cur_nonce);
            state_q           <= StB2Req;
          end
        end
        StB2Req: state_q <= StB2Wait;
        StB2Wait: begin
          if (core.core_done) begin
            core.core_start   <= 1'b1;
            core.core_h_block <= ShaIv;
            core.core_message <= b3_message(core.core_h_out);
            state_q           <= StB3Req;
          end
        end
        StB3Req: state_q <= StB3Wait;
        StB3Wait: begin
          if (core.core_done) begin
            digest       <= word_reverse(core.core_h_out);
            result_nonce <= cur_nonce;
            state_q      <= StEmit;
          end
        end
        StEmit: begin
          result_valid <= 1'b1;
          if (n_q == LastN) begin
            state_q <= StFinish;
          end else begin
            n_q               <= n_q + 32'd1;
            core.core_start   <= 1'b1;
            core.core_h_block <= midstate_q;
            core.core_message <= b2_message(hdr_q[95:0], next_nonce);
            state_q           <= StB2Req;
          end
        end
        StFinish: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_feeder.sv
// Bench for sha256_nonce_feeder: a behavioural SHA-256 core with random latency answers the
// feeder, and a scoreboard of SHA256d digests computed from the header checks every result.
module tb_sha256_nonce_feeder;

  localparam int unsigned NumNonces = 4;
  localparam logic [255:0] IvBe =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] GenesisDigest =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [639:0] GenesisHeader = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [639:0] header;
  logic [31:0]  nonce_base;
  logic         busy, done, result_valid;
  logic [31:0]  result_nonce;
  logic [255:0] digest;

  sha256_nonce_feeder_if core_if ();

  sha256_nonce_feeder #(.NUM_NONCES(NumNonces)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .header       (header),
    .nonce_base   (nonce_base),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .result_nonce (result_nonce),
    .digest       (digest),
    .core         (core_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] swap8(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = x[32*i +: 32];
    return r;
  endfunction

  // Reference compression, h0 in the top word.
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
             + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] hdr, input logic [31:0] nonce);
    logic [255:0] mid, h1;
    mid = sha_compress(IvBe, hdr[639:128]);
    h1  = sha_compress(mid, {hdr[127:32], nonce, 32'h80000000, 320'h0, 32'h00000280});
    return sha_compress(IvBe, {h1, 32'h80000000, 192'h0, 32'h00000100});
  endfunction

  function automatic logic [639:0] rand_header();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural core: random latency, checks its inputs stay put while it works.
  int           lat_min = 1, lat_max = 1;
  int           spur_at = -1;
  int           start_cnt = 0;
  int           stub_err = 0;
  bit           prev_cs = 1'b0, pending = 1'b0;
  int           lat_cnt = 0;
  logic [511:0] pend_msg;
  logic [255:0] pend_h, pend_res;

  always @(negedge clk) begin
    core_if.core_done = 1'b0;
    if (!reset_n) begin
      pending = 1'b0;
      prev_cs = 1'b0;
      core_if.core_h_out = '0;
    end else begin
      if (pending) begin
        if (core_if.core_message !== pend_msg || core_if.core_h_block !== pend_h) stub_err++;
        if (lat_cnt == 0) begin
          core_if.core_done  = 1'b1;
          core_if.core_h_out = pend_res;
          pending = 1'b0;
        end else begin
          lat_cnt--;
        end
      end
      if (core_if.core_start === 1'b1) begin
        start_cnt++;
        if (prev_cs || pending) stub_err++;
        pending  = 1'b1;
        pend_msg = core_if.core_message;
        pend_h   = core_if.core_h_block;
        pend_res = swap8(sha_compress(swap8(core_if.core_h_block), core_if.core_message));
        lat_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        if (start_cnt == spur_at) begin
          core_if.core_done  = 1'b1;
          core_if.core_h_out = ~pend_res;
        end
      end
      prev_cs = core_if.core_start;
    end
  end

  typedef struct packed {
    logic [31:0]  nonce;
    logic [255:0] dig;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0]  got_nonce [NumNonces];
  logic [255:0] got_dig [NumNonces];
  int           sweep_rv, starts_in_sweep, errs_in_sweep;
  logic         cs_after_start, busy_after_start;

  task automatic run_sweep(input logic [639:0] hdr, input logic [31:0] base, input int budget,
                           input bit poke);
    exp_t e;
    bit   got_done, prev_rv;
    int   s0, e0;
    for (int i = 0; i < NumNonces; i++) begin
      e.nonce = base + 32'(i);
      e.dig   = sha256d(hdr, e.nonce);
      exp_q.push_back(e);
    end
    s0 = start_cnt;
    e0 = stub_err;
    @(negedge clk);
    header = hdr; nonce_base = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cs_after_start   = core_if.core_start;
    busy_after_start = busy;
    sweep_rv = 0; got_done = 1'b0; prev_rv = 1'b0;
    for (int c = 0; c < budget && !got_done; c++) begin
      @(negedge clk);
      if (result_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_result got nonce=%h want none", result_nonce);
        end else begin
          e = exp_q.pop_front();
          if (result_nonce !== e.nonce) begin
            bad++;
            $display("FAIL result_nonce got=%h want=%h", result_nonce, e.nonce);
          end
          total++;
          if (digest !== e.dig) begin
            bad++;
            $display("FAIL digest nonce=%h got=%h want=%h", e.nonce, digest, e.dig);
          end
        end
        if (sweep_rv < NumNonces) begin
          got_nonce[sweep_rv] = result_nonce;
          got_dig[sweep_rv]   = digest;
        end
        sweep_rv++;
      end
      if (done) begin
        got_done = 1'b1;
        total++;
        if (prev_rv !== 1'b1) begin
          bad++;
          $display("FAIL done_after_valid got prev_valid=%b want 1", prev_rv);
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_with_done got=%b want 0", busy);
        end
      end
      prev_rv = result_valid;
      if (poke) begin
        start = (c >= 2 && c < 8);
        if (start) begin header = rand_header(); nonce_base = $urandom; end
      end
    end
    start = 1'b0;
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL sweep_timeout got done=0 want 1 within %0d cycles", budget);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_results got=%0d want=0 outstanding", exp_q.size());
    end
    exp_q.delete();
    starts_in_sweep = start_cnt - s0;
    errs_in_sweep   = stub_err - e0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; header = '0; nonce_base = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want 0", done); end
    total++;
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want 0", result_valid);
    end
    total++;
    if (core_if.core_start !== 1'b0) begin
      bad++; $display("FAIL rst_core_start got=%b want 0", core_if.core_start);
    end
    total++; if (digest !== '0) begin bad++; $display("FAIL rst_digest got=%h want 0", digest); end
    total++;
    if (result_nonce !== '0) begin
      bad++; $display("FAIL rst_nonce got=%h want 0", result_nonce);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_genesis();
    lat_min = 1; lat_max = 1;
    run_sweep(GenesisHeader, 32'h1dac2b7c, 500, 1'b0);
    total++;
    if (got_dig[0] !== GenesisDigest) begin
      bad++; $display("FAIL genesis_digest got=%h want=%h", got_dig[0], GenesisDigest);
    end
    total++;
    if (got_nonce[0] !== 32'h1dac2b7c) begin
      bad++; $display("FAIL genesis_nonce got=%h want=1dac2b7c", got_nonce[0]);
    end
    total++;
    if (cs_after_start !== 1'b1) begin
      bad++; $display("FAIL first_core_start got=%b want 1", cs_after_start);
    end
    total++;
    if (busy_after_start !== 1'b1) begin
      bad++; $display("FAIL busy_rise got=%b want 1", busy_after_start);
    end
  endtask

  task automatic test_four_nonces();
    lat_min = 1; lat_max = 3;
    run_sweep(GenesisHeader, 32'h1dac2b7a, 800, 1'b0);
    total++;
    if (sweep_rv != NumNonces) begin
      bad++; $display("FAIL valid_count got=%0d want=%0d", sweep_rv, NumNonces);
    end
    total++;
    if (got_nonce[2] !== 32'h1dac2b7c || got_dig[2] !== GenesisDigest) begin
      bad++; $display("FAIL third_result got=%h/%h want=1dac2b7c/%h", got_nonce[2], got_dig[2],
                      GenesisDigest);
    end
    total++;
    if (starts_in_sweep != 2 * NumNonces + 1) begin
      bad++; $display("FAIL core_calls got=%0d want=%0d", starts_in_sweep, 2 * NumNonces + 1);
    end
  endtask

  task automatic test_variable_latency();
    lat_min = 1; lat_max = 200;
    run_sweep(GenesisHeader, 32'h1dac2b7a, 4000, 1'b0);
    total++;
    if (got_dig[2] !== GenesisDigest) begin
      bad++; $display("FAIL varlat_digest got=%h want=%h", got_dig[2], GenesisDigest);
    end
    total++;
    if (errs_in_sweep != 0) begin
      bad++; $display("FAIL core_bus_protocol got=%0d violations want=0", errs_in_sweep);
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 5;
    run_sweep(rand_header(), 32'hffffffff, 800, 1'b0);
    total++;
    if (got_nonce[0] !== 32'hffffffff) begin
      bad++; $display("FAIL wrap_first got=%h want=ffffffff", got_nonce[0]);
    end
    total++;
    if (got_nonce[1] !== 32'h00000000) begin
      bad++; $display("FAIL wrap_second got=%h want=00000000", got_nonce[1]);
    end
  endtask

  task automatic test_start_while_busy();
    lat_min = 3; lat_max = 10;
    spur_at = start_cnt + 2;
    run_sweep(rand_header(), $urandom, 1000, 1'b1);
    spur_at = -1;
    total++;
    if (starts_in_sweep != 2 * NumNonces + 1) begin
      bad++; $display("FAIL busy_start_calls got=%0d want=%0d", starts_in_sweep,
                      2 * NumNonces + 1);
    end
    total++;
    if (errs_in_sweep != 0) begin
      bad++; $display("FAIL busy_start_protocol got=%0d violations want=0", errs_in_sweep);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || core_if.core_start !== 1'b0) begin
      bad++; $display("FAIL idle_after_sweep got busy=%b core_start=%b want 0/0", busy,
                      core_if.core_start);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int s0;
    lat_min = 60; lat_max = 60;
    s0 = start_cnt;
    @(negedge clk);
    header = GenesisHeader; nonce_base = 32'h1dac2b7c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300 && (start_cnt - s0) < 2; c++) @(negedge clk);
    total++;
    if (start_cnt - s0 != 2) begin
      bad++; $display("FAIL reach_b2 got=%0d calls want=2", start_cnt - s0);
    end
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0 ||
        core_if.core_start !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl got busy=%b done=%b valid=%b cs=%b want 0", busy, done,
                      result_valid, core_if.core_start);
    end
    total++;
    if (digest !== '0 || result_nonce !== '0) begin
      bad++; $display("FAIL midrst_data got=%h/%h want 0/0", digest, result_nonce);
    end
    @(negedge clk);
    reset_n = 1'b1;
    lat_min = 1; lat_max = 4;
    run_sweep(rand_header(), $urandom, 800, 1'b0);
    total++;
    if (sweep_rv != NumNonces || starts_in_sweep != 2 * NumNonces + 1) begin
      bad++; $display("FAIL post_reset_sweep got=%0d/%0d want=%0d/%0d", sweep_rv,
                      starts_in_sweep, NumNonces, 2 * NumNonces + 1);
    end
  endtask

  initial begin
    test_reset();
    test_genesis();
    test_four_nonces();
    test_variable_latency();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
